instruction_fetch_unit: RTL

//  Sequences the instruction memory: owns the fetch PC, drives the word-aligned read address,
//  and captures returned words into a small prefetch FIFO.

---
 rtl/instruction_fetch_unit_pkg.sv | 22 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 68 ++++++
 rtl/instruction_fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, constants and the prefetch entry layout for the fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] WORD_OFFSET  = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] addr
    );
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO; Flush clears it exactly like reset.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             Push,
    input  logic [WIDTH-1:0] DIn,
    input  logic             Pop,
    output logic [WIDTH-1:0] DOut,
    output logic [CW-1:0]    Count,
    output logic             Full,
    output logic             Empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign Full    = (count_q == CW'(DEPTH));
    assign Empty   = (count_q == '0);
    assign do_pop  = Pop & ~Empty;
    // When full, the slot written is the one being popped this cycle.
    assign do_push = Push & (~Full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !Flush && !Rst) begin
            mem_q[wr_ptr_q] <= DIn;
        end
    end

    assign DOut  = mem_q[rd_ptr_q];
    assign Count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC sequencer with prefetch FIFO and redirect flush, feeding decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned MEM_WORDS  = 396,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Rst,
    output logic [ADDR_W-1:0]  ImemAddress,
    input  logic [INSTR_W-1:0] ImemInstruction,
    output logic               IfValid,
    output logic [INSTR_W-1:0] IfInstruction,
    output logic [ADDR_W-1:0]  IfPC,
    output logic [ADDR_W-1:0]  IfPCPlus4,
    input  logic               IdReady,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               FetchDone,
    output logic [OCC_W-1:0]   Occupancy
);

    // One extra bit so the end bound never aliases near 2^32.
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(MEM_WORDS) << 2;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              in_range;
    logic              push, pop;
    logic              full, empty;
    logic [OCC_W-1:0]  count;
    logic [ENTRY_W-1:0] head_raw;
    fetch_entry_t      head, wr_entry;

    assign in_range = ({1'b0, fetch_pc_q} < END_ADDR);
    assign pop      = ~empty & IdReady;
    assign push     = ~Redirect & in_range & (~full | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Redirect) begin
            fetch_pc_d = word_align(RedirectPC);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + WORD_OFFSET;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign wr_entry.instr = ImemInstruction;
    assign wr_entry.pc    = fetch_pc_q;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .Flush (Redirect),
        .Push  (push),
        .DIn   (wr_entry),
        .Pop   (pop),
        .DOut  (head_raw),
        .Count (count),
        .Full  (full),
        .Empty (empty)
    );

    assign head          = fetch_entry_t'(head_raw);
    assign ImemAddress   = fetch_pc_q;
    assign IfValid       = ~empty;
    assign IfInstruction = empty ? '0 : head.instr;
    assign IfPC          = empty ? '0 : head.pc;
    assign IfPCPlus4     = empty ? '0 : head.pc + WORD_OFFSET;
    assign FetchDone     = ~in_range & empty;
    assign Occupancy     = count;

endmodule
